vga_pattern_gen: RTL and testbench
==================================

# vga_pattern_gen

- Pixel source for the VGA video path: generates 640x480@60 raster timing plus an 8-band 3-bit colour-bar test pattern.
- Outputs the horizontal pixel index and RGB word consumed by the downstream colour-remap stage, and the sync/blanking signals for the DAC/connector.
- Runs on the system clock, advanced by a pixel clock-enable strobe.

## Interface

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- BAR_W, 80, width of one colour band in pixels (H_ACTIVE/8)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk_i  input  1  system clock
  - rst_ni  input  1  asynchronous active-low reset
- pix_ce_i  input  1  pixel clock enable; the raster advances only on clk_i edges where this is 1
- hsync_o  output  1  horizontal sync, active low
- vsync_o  output  1  vertical sync, active low
- de_o  output  1  data enable; 1 during visible area
- row_o  output  10  horizontal pixel index within the line, 0..H_ACTIVE-1 while de_o=1, 0 otherwise
- line_o  output  10  vertical line index, 0..V_ACTIVE-1 while de_o=1, 0 otherwise
- rgb_o  output  3  pixel colour, {R,G,B}
- frame_o  output  1  one-enabled-cycle pulse marking pixel (0,0) of each frame

## Operation

- Counters:
  - h_cnt counts 0..H_TOT-1, where H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - v_cnt counts 0..V_TOT-1, where V_TOT = 525.
  - v_cnt increments when h_cnt wraps from H_TOT-1 to 0.
  - v_cnt wraps from V_TOT-1 to 0 when h_cnt also wraps.
- Horizontal phase FSM, tracked from h_cnt:
  - ACTIVE (0..639) -> FRONT (640..655) -> SYNC (656..751) -> BACK (752..799) -> ACTIVE.
  - The vertical phases use the same structure on v_cnt: ACTIVE 0..479, FRONT 480..489, SYNC 490..491, BACK 492..524.
- Output decode:
  - hsync_o = 0 in the horizontal SYNC phase.
  - vsync_o = 0 in the vertical SYNC phase.
  - de_o = 1 when both the horizontal and vertical phases are ACTIVE.
- Colour bars:
  - Band index k = px / BAR_W, in the range 0..7, where px is the effective pixel position.
  - rgb_o = k[2:0], giving BLACK, BLUE, GREEN, CYAN, RED, PURPLE, YELLOW, WHITE from left to right.
  - rgb_o = 000 whenever de_o = 0.
- frame_o = 1 exactly when h_cnt=0 and v_cnt=0.
- pix_ce_i = 0: counters and all outputs hold their values.
- Width rules:
  - Counters are 10 bits.
  - The band index is computed with compare/subtract against multiples of BAR_W; no divider is used.
  - px < H_ACTIVE is guaranteed before indexing.

## Timing

- Reset values (asynchronous, applied immediately on rst_ni=0):
  - Counters: h_cnt=0, v_cnt=0.
  - Outputs: hsync_o=1, vsync_o=1, de_o=0, row_o=0, line_o=0, rgb_o=000, frame_o=0.
- All outputs are registered.
  - Each enabled cycle registers values decoded from the pre-increment counters.
  - Latency is therefore one enabled cycle from counter value to output.
- First enabled cycle after reset release: de_o=1, row_o=0, line_o=0, rgb_o=000, frame_o=1.
- Reset asserted mid-frame returns everything to the reset values. The next frame restarts at (0,0) with no partial-line recovery.
- Line wrap (h_cnt 799->0) and frame wrap (v_cnt 524->0) both occur on the same enabled edge. No extra cycle is inserted.
- One line is 800 enabled cycles; one frame is 420000 enabled cycles.
- hsync_o low width: 96 enabled cycles.
- vsync_o low width: 2 lines (1600 enabled cycles), asserting coincident with h_cnt=0.

## Configuration

- Macro: VGA_PATTERN_GEN_SCROLL_EN.
- Defined:
  - A 10-bit scroll offset register is added; it resets to 0.
  - The offset increments on each frame wrap and wraps from H_ACTIVE-1 to 0.
  - Effective position px = (h_cnt + offset) mod H_ACTIVE, implemented by a single conditional subtract.
  - Bars move left one pixel per frame.
  - row_o still reports unshifted h_cnt.
- Undefined: px = h_cnt. The pattern is static and the offset logic is absent.

## Test plan

- Reset, then pix_ce_i=1 continuously:
  - First cycle: frame_o=1, de_o=1, row_o=0, rgb_o=000.
  - frame_o next pulses exactly 420000 cycles later.
- Line 0, pix_ce_i=1:
  - rgb_o=000 for row_o 0..79, 001 for 80..159, and so on through 111 for 560..639.
  - de_o falls at h_cnt=640 with rgb_o=000.
  - hsync_o is low exactly 96 cycles, starting at h_cnt=656.
- Vertical sync: vsync_o is low exactly 1600 cycles, starting at v_cnt=490, h_cnt=0.
- pix_ce_i toggled 1/0 each clk: the output sequence is identical to the continuous case, with each value held for 2 clk. No output changes on a pix_ce_i=0 edge.
- rst_ni pulsed low mid-line (v_cnt=200, h_cnt=300): all outputs take their reset values immediately. The first enabled cycle after release shows frame_o=1, row_o=0.
- With VGA_PATTERN_GEN_SCROLL_EN defined:
  - In frame 1, pixel row_o=79 shows rgb_o=001.
  - In frame 80, row_o=0 shows rgb_o=001.
  - After 640 frames the pattern matches frame 0.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// +--------------------------------------------------------------------------+
// | vga_pattern_gen: 640x480@60 raster timing with an 8-band colour-bar test |
// | pattern. Optional scrolling bars: define VGA_PATTERN_GEN_SCROLL_EN.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module vga_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int BAR_W    = 80
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pix_ce_i,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       de_o,
  output logic [9:0] row_o,
  output logic [9:0] line_o,
  output logic [2:0] rgb_o,
  output logic       frame_o
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_END_ACT  = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_END_FP   = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] H_END_SYNC = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_END_TOT  = 10'(H_TOT - 1);
  localparam logic [9:0] V_END_ACT  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_END_FP   = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0] V_END_SYNC = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_END_TOT  = 10'(V_TOT - 1);

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  // Phase leaves its state on the last count of that region.
  function automatic phase_e phase_next(input phase_e cur, input logic [9:0] cnt,
                                        input logic [9:0] e_act, input logic [9:0] e_fp,
                                        input logic [9:0] e_sync, input logic [9:0] e_tot);
    phase_e nxt;
    nxt = cur;
    case (cur)
      PH_ACTIVE: if (cnt == e_act)  nxt = PH_FRONT;
      PH_FRONT:  if (cnt == e_fp)   nxt = PH_SYNC;
      PH_SYNC:   if (cnt == e_sync) nxt = PH_BACK;
      PH_BACK:   if (cnt == e_tot)  nxt = PH_ACTIVE;
      default:   nxt = PH_ACTIVE;
    endcase
    return nxt;
  endfunction

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  phase_e     hph_q, hph_d;
  phase_e     vph_q, vph_d;
  logic       h_wrap, frame_wrap, active;
  logic [9:0] px;
  logic [2:0] band;

  logic       hsync_q, vsync_q, de_q, frame_q;
  logic [9:0] row_q, line_q;
  logic [2:0] rgb_q;

  always_comb begin
    h_wrap     = (h_cnt_q == H_END_TOT);
    frame_wrap = h_wrap && (v_cnt_q == V_END_TOT);
    h_cnt_d    = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
    v_cnt_d    = v_cnt_q;
    vph_d      = vph_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_END_TOT) ? 10'd0 : v_cnt_q + 10'd1;
      vph_d   = phase_next(vph_q, v_cnt_q, V_END_ACT, V_END_FP, V_END_SYNC, V_END_TOT);
    end
    hph_d  = phase_next(hph_q, h_cnt_q, H_END_ACT, H_END_FP, H_END_SYNC, H_END_TOT);
    active = (hph_q == PH_ACTIVE) && (vph_q == PH_ACTIVE);
  end

`ifdef VGA_PATTERN_GEN_SCROLL_EN
  logic [9:0]  offset_q;
  logic [10:0] px_sum;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      offset_q <= '0;
    end else if (pix_ce_i && frame_wrap) begin
      offset_q <= (offset_q == H_END_ACT) ? 10'd0 : offset_q + 10'd1;
    end
  end

  // Both operands are below H_ACTIVE in the visible area, so one subtract suffices.
  assign px_sum = {1'b0, h_cnt_q} + {1'b0, offset_q};
  assign px     = (px_sum >= 11'(H_ACTIVE)) ? 10'(px_sum - 11'(H_ACTIVE)) : px_sum[9:0];
`else
  assign px = h_cnt_q;
`endif

  always_comb begin
    band = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (px >= 10'(BAR_W * i)) band = 3'(i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hph_q   <= PH_ACTIVE;
      vph_q   <= PH_ACTIVE;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      row_q   <= '0;
      line_q  <= '0;
      rgb_q   <= '0;
      frame_q <= 1'b0;
    end else if (pix_ce_i) begin
      hsync_q <= (hph_q != PH_SYNC);
      vsync_q <= (vph_q != PH_SYNC);
      de_q    <= active;
      row_q   <= active ? h_cnt_q : 10'd0;
      line_q  <= active ? v_cnt_q : 10'd0;
      rgb_q   <= active ? band : 3'd0;
      frame_q <= (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hph_q   <= hph_d;
      vph_q   <= vph_d;
    end
  end

  assign hsync_o = hsync_q;
  assign vsync_o = vsync_q;
  assign de_o    = de_q;
  assign row_o   = row_q;
  assign line_o  = line_q;
  assign rgb_o   = rgb_q;
  assign frame_o = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
// +--------------------------------------------------------------------------+
// | tb_vga_pattern_gen: scoreboard bench for vga_pattern_gen on a reduced   |
// | raster (80x12 total) so whole frames fit in a short run. Rev 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_vga_pattern_gen;

  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 2;
  localparam int BW = 8;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam logic [26:0] RST_VEC = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 3'd0, 1'b0};

  logic       clk_i, rst_ni, pix_ce_i;
  logic       hsync_o, vsync_o, de_o, frame_o;
  logic [9:0] row_o, line_o;
  logic [2:0] rgb_o;
  logic [26:0] got;

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .BAR_W(BW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .pix_ce_i(pix_ce_i),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
    .row_o(row_o), .line_o(line_o), .rgb_o(rgb_o), .frame_o(frame_o)
  );

  assign got = {hsync_o, vsync_o, de_o, row_o, line_o, rgb_o, frame_o};

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;
  int mh, mv, moff, last_h, last_v;
  logic [26:0] q[$];
  logic [26:0] last_exp, exp_v;

  function automatic logic [26:0] model_out();
    logic de, hs, vs;
    int px;
    de = (mh < HA) && (mv < VA);
    hs = !((mh >= HA + HF) && (mh < HA + HF + HS));
    vs = !((mv >= VA + VF) && (mv < VA + VF + VS));
    px = (mh + moff) % HA;
    return {hs, vs, de, de ? 10'(mh) : 10'd0, de ? 10'(mv) : 10'd0,
            de ? 3'(px / BW) : 3'd0, (mh == 0) && (mv == 0)};
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; moff = 0;
    last_exp = RST_VEC;
    q.delete();
  endtask

  // Push the expected registered outputs for this clock, then advance one clk.
  task automatic tick(input logic ce);
    pix_ce_i = ce;
    last_h = mh;
    last_v = mv;
    if (ce) begin
      last_exp = model_out();
      mh = mh + 1;
      if (mh == HT) begin
        mh = 0;
        mv = mv + 1;
        if (mv == VT) begin
          mv = 0;
`ifdef VGA_PATTERN_GEN_SCROLL_EN
          moff = (moff + 1) % HA;
`endif
        end
      end
    end
    q.push_back(last_exp);
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    pix_ce_i = 1'b1;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    n_cmp++;
    if (got !== RST_VEC) begin
      n_err++;
      $display("FAIL reset_values got=%h exp=%h", got, RST_VEC);
    end
  endtask

  task automatic test_first_cycle();
    rst_ni = 1'b1;
    tick(1'b1);
    exp_v = q.pop_front();
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL first_cycle got=%h exp=%h", got, exp_v);
    end
    n_cmp++;
    if (frame_o !== 1'b1 || de_o !== 1'b1 || rgb_o !== 3'd0) begin
      n_err++;
      $display("FAIL first_frame_pulse got frame=%b de=%b rgb=%b exp 1 1 000", frame_o, de_o, rgb_o);
    end
  endtask

  task automatic test_line0();
    int hs_low, hs_start;
    hs_low = 0;
    hs_start = -1;
    for (int i = 1; i < HT; i++) begin
      tick(1'b1);
      exp_v = q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL line0_h%0d got=%h exp=%h", last_h, got, exp_v);
      end
      if (hsync_o === 1'b0) begin
        if (hs_start < 0) hs_start = last_h;
        hs_low++;
      end
    end
    n_cmp++;
    if (hs_low != HS || hs_start != HA + HF) begin
      n_err++;
      $display("FAIL hsync_width got len=%0d start=%0d exp len=%0d start=%0d",
               hs_low, hs_start, HS, HA + HF);
    end
  endtask

  task automatic test_frame();
    int gap, vs_low, vs_start_h, vs_start_v;
    bit seen;
    seen = 0;
    gap = 0;
    vs_low = 0;
    vs_start_h = -1;
    vs_start_v = -1;
    for (int i = 0; i < 3 * HT * VT; i++) begin
      tick(1'b1);
      exp_v = q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL frame_v%0d_h%0d got=%h exp=%h", last_v, last_h, got, exp_v);
      end
      if (seen) begin
        gap++;
        if (vsync_o === 1'b0) begin
          if (vs_start_v < 0) begin
            vs_start_v = last_v;
            vs_start_h = last_h;
          end
          vs_low++;
        end
      end
      if (frame_o === 1'b1) begin
        if (seen) break;
        seen = 1;
      end
    end
    n_cmp++;
    if (gap != HT * VT) begin
      n_err++;
      $display("FAIL frame_period got=%0d exp=%0d", gap, HT * VT);
    end
    n_cmp++;
    if (vs_low != VS * HT || vs_start_v != VA + VF || vs_start_h != 0) begin
      n_err++;
      $display("FAIL vsync_width got len=%0d at v%0d h%0d exp len=%0d at v%0d h0",
               vs_low, vs_start_v, vs_start_h, VS * HT, VA + VF);
    end
  endtask

  task automatic test_ce_toggle();
    for (int i = 0; i < 4 * HT; i++) begin
      tick((i % 2) == 0);
      exp_v = q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL ce_toggle_clk%0d got=%h exp=%h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 2 * HT * VT && !(mv == 3 && mh == 30); i++) begin
      tick(1'b1);
      exp_v = q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL pre_reset got=%h exp=%h", got, exp_v);
      end
    end
    #3;
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if (got !== RST_VEC) begin
      n_err++;
      $display("FAIL mid_reset_async got=%h exp=%h", got, RST_VEC);
    end
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    tick(1'b1);
    exp_v = q.pop_front();
    n_cmp++;
    if (got !== exp_v || frame_o !== 1'b1 || row_o !== 10'd0) begin
      n_err++;
      $display("FAIL mid_reset_restart got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_back_to_back(input int frames);
    for (int i = 0; i < frames * HT * VT + 1; i++) begin
      tick(1'b1);
      exp_v = q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL b2b_off%0d_v%0d_h%0d got=%h exp=%h", moff, last_v, last_h, got, exp_v);
      end
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    pix_ce_i = 1'b0;
    model_reset();
    test_reset();
    test_first_cycle();
    test_line0();
    test_frame();
    test_ce_toggle();
    test_mid_reset();
    test_back_to_back(1);
`ifdef VGA_PATTERN_GEN_SCROLL_EN
    test_back_to_back(HA);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
